ram_access_ctrl: RTL and testbench

RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

---
 rtl/ram_defs_pkg.sv | 17 +
 rtl/rsp_fifo.sv | 63 ++++++
 rtl/ram_access_ctrl.sv | 137 +++++++++++++
 tb/tb_ram_access_ctrl.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_defs_pkg.sv
// Shared RAM block definitions: default data/address widths, response depth,
// post-reset drain window and a counter-width helper.
package ram_defs_pkg;

  localparam int unsigned RAM_WIDTH_DEF = 64;
  localparam int unsigned ADDR_SIZE_DEF = 12;
  localparam int unsigned RSP_DEPTH_DEF = 4;

  // Cycles after reset release during which stray RAM returns are silently dropped.
  localparam int unsigned DRAIN_CYCLES = 2;

  // Bits needed to hold a count in the range 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Synchronous first-word-fall-through FIFO for read responses.
// Ports:
//   clk, rst        clock, synchronous active-high reset (empties the FIFO)
//   push, push_data write side; a push while full is taken only with a pop
//   pop             removes the head; ignored when empty
//   valid, head     FIFO not empty / current head word
//   count           number of stored words (0..DEPTH)
// A push into an empty FIFO becomes visible on the following cycle (no bypass).
module rsp_fifo
  import ram_defs_pkg::*;
#(
  parameter int unsigned WIDTH = RAM_WIDTH_DEF,
  parameter int unsigned DEPTH = RSP_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic [WIDTH-1:0]              push_data,
  input  logic                          pop,
  output logic                          valid,
  output logic [WIDTH-1:0]              head,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = cnt_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pop only real data; a full FIFO still accepts a push that coincides with a pop.
  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);

  assign valid = (count != '0);
  assign head  = mem[rd_ptr];

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage array; contents need no reset since valid gates them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ram_access_ctrl.sv
// Request/response front end for a single-port-per-direction RAM.
// Ports:
//   clk, rst                                 clock, synchronous active-high reset
//   wr_req_valid/ready/addr/data             write request handshake
//   rd_req_valid/ready/addr                  read request handshake
//   rd_rsp_valid/ready/data                  in-order read responses (FWFT)
//   ram_data_in, ram_wr_address, ram_write   registered RAM write strobe/bus
//   ram_rd_address, ram_read                 registered RAM read strobe/bus
//   ram_data_out, ram_data_valid             RAM read return (any latency)
//   err_spurious                             sticky: RAM data with no read pending
module ram_access_ctrl
  import ram_defs_pkg::*;
#(
  parameter int unsigned RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int unsigned ADDR_SIZE = ADDR_SIZE_DEF,
  parameter int unsigned RSP_DEPTH = RSP_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_req_valid,
  output logic                 wr_req_ready,
  input  logic [ADDR_SIZE-1:0] wr_req_addr,
  input  logic [RAM_WIDTH-1:0] wr_req_data,
  input  logic                 rd_req_valid,
  output logic                 rd_req_ready,
  input  logic [ADDR_SIZE-1:0] rd_req_addr,
  output logic                 rd_rsp_valid,
  input  logic                 rd_rsp_ready,
  output logic [RAM_WIDTH-1:0] rd_rsp_data,
  output logic [RAM_WIDTH-1:0] ram_data_in,
  output logic [ADDR_SIZE-1:0] ram_wr_address,
  output logic [ADDR_SIZE-1:0] ram_rd_address,
  output logic                 ram_write,
  output logic                 ram_read,
  input  logic [RAM_WIDTH-1:0] ram_data_out,
  input  logic                 ram_data_valid,
  output logic                 err_spurious
);

  localparam int unsigned CNT_W   = cnt_width(RSP_DEPTH);
  localparam int unsigned SUM_W   = CNT_W + 1;
  localparam int unsigned DRAIN_W = cnt_width(DRAIN_CYCLES);

  logic               wr_fire;
  logic               rd_fire;
  logic               raw_hazard;
  logic               credit_ok;
  logic               rsp_push;
  logic               rsp_pop;
  logic [CNT_W-1:0]   outstanding;
  logic [CNT_W-1:0]   fifo_count;
  logic [SUM_W-1:0]   committed;
  logic [DRAIN_W-1:0] drain_cnt;

  assign wr_req_ready = !rst;
  assign wr_fire      = wr_req_valid && wr_req_ready;

  // Hold a read while a write to the same address is being accepted now or is
  // on the RAM write port this cycle, so the read never sees stale data.
  assign raw_hazard = (wr_fire && (rd_req_addr == wr_req_addr)) ||
                      (ram_write && (rd_req_addr == ram_wr_address));

  // Every slot already spoken for: queued, in the RAM, or strobing right now.
  assign committed = SUM_W'(fifo_count) + SUM_W'(outstanding) + SUM_W'(ram_read);
  assign credit_ok = (committed < SUM_W'(RSP_DEPTH));

  assign rd_req_ready = !rst && credit_ok && !raw_hazard;
  assign rd_fire      = rd_req_valid && rd_req_ready;

  assign rsp_push = ram_data_valid && (outstanding != '0);
  assign rsp_pop  = rd_rsp_valid && rd_rsp_ready;

  // RAM strobes and buses: one-cycle pulse the cycle after acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_write      <= 1'b0;
      ram_read       <= 1'b0;
      ram_wr_address <= '0;
      ram_rd_address <= '0;
      ram_data_in    <= '0;
    end else begin
      ram_write <= wr_fire;
      ram_read  <= rd_fire;
      if (wr_fire) begin
        ram_wr_address <= wr_req_addr;
        ram_data_in    <= wr_req_data;
      end
      if (rd_fire) ram_rd_address <= rd_req_addr;
    end
  end

  // Reads issued to the RAM whose data has not yet returned.
  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({ram_read, rsp_push})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Returns from reads issued before a reset may still arrive; ignore them briefly.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= DRAIN_W'(DRAIN_CYCLES);
    end else if (drain_cnt != '0) begin
      drain_cnt <= drain_cnt - DRAIN_W'(1);
    end
  end

  // Sticky flag for RAM data nobody asked for.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_spurious <= 1'b0;
    end else if (ram_data_valid && (outstanding == '0) && (drain_cnt == '0)) begin
      err_spurious <= 1'b1;
    end
  end

  rsp_fifo #(
    .WIDTH (RAM_WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_push),
    .push_data (ram_data_out),
    .pop       (rsp_pop),
    .valid     (rd_rsp_valid),
    .head      (rd_rsp_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl: directed scenarios plus a random
// phase, with a behavioural RAM (variable latency, read-before-write) and a
// shadow-memory reference that predicts every read response in request order.
module tb_ram_access_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_req_valid;
  logic          wr_req_ready;
  logic [AW-1:0] wr_req_addr;
  logic [DW-1:0] wr_req_data;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [AW-1:0] rd_req_addr;
  logic          rd_rsp_valid;
  logic          rd_rsp_ready;
  logic [DW-1:0] rd_rsp_data;
  logic [DW-1:0] ram_data_in;
  logic [AW-1:0] ram_wr_address;
  logic [AW-1:0] ram_rd_address;
  logic          ram_write;
  logic          ram_read;
  logic [DW-1:0] ram_data_out   = '0;
  logic          ram_data_valid = 1'b0;
  logic          err_spurious;

  always #5 clk = ~clk;

  ram_access_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .wr_req_valid   (wr_req_valid),
    .wr_req_ready   (wr_req_ready),
    .wr_req_addr    (wr_req_addr),
    .wr_req_data    (wr_req_data),
    .rd_req_valid   (rd_req_valid),
    .rd_req_ready   (rd_req_ready),
    .rd_req_addr    (rd_req_addr),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_ready   (rd_rsp_ready),
    .rd_rsp_data    (rd_rsp_data),
    .ram_data_in    (ram_data_in),
    .ram_wr_address (ram_wr_address),
    .ram_rd_address (ram_rd_address),
    .ram_write      (ram_write),
    .ram_read       (ram_read),
    .ram_data_out   (ram_data_out),
    .ram_data_valid (ram_data_valid),
    .err_spurious   (err_spurious)
  );

  // ---------------- behavioural RAM ----------------
  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } pend_t;

  pend_t         ram_q[$];
  logic [DW-1:0] ram_mem [int];
  int            cyc        = 0;
  int            spur_req   = 0;
  int            spur_done  = 0;
  bit            ram_hold   = 1'b0;
  bit            ram_jitter = 1'b1;

  // Strobes are stable at the falling edge; returns are driven there for the next rising edge.
  always @(negedge clk) begin
    pend_t p;
    cyc++;
    if (ram_read) begin
      p.data = ram_mem.exists(int'(ram_rd_address)) ? ram_mem[int'(ram_rd_address)] : '0;
      p.due  = cyc + int'($urandom_range(1, 3));
      ram_q.push_back(p);
    end
    if (ram_write) ram_mem[int'(ram_wr_address)] = ram_data_in;
    ram_data_valid = 1'b0;
    if (spur_req != spur_done) begin
      ram_data_valid = 1'b1;
      ram_data_out   = {$urandom, $urandom};
      spur_done++;
    end else if (!ram_hold && ram_q.size() != 0 && ram_q[0].due <= cyc &&
                 (!ram_jitter || $urandom_range(0, 3) != 0)) begin
      p = ram_q.pop_front();
      ram_data_valid = 1'b1;
      ram_data_out   = p.data;
    end
  end

  // ---------------- reference model and checking ----------------
  logic [DW-1:0] shadow [int];
  logic [DW-1:0] exp_q[$];
  int            n_checks = 0;
  int            n_err    = 0;
  int            n_pop    = 0;
  bit            rst_cmd  = 1'b1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, settle, then model what the next rising edge does.
  task automatic tick(input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input bit rv, input logic [AW-1:0] ra, input bit rr,
                      output bit wf, output bit rf);
    @(negedge clk);
    rst          = rst_cmd;
    wr_req_valid = wv;
    wr_req_addr  = wa;
    wr_req_data  = wd;
    rd_req_valid = rv;
    rd_req_addr  = ra;
    rd_rsp_ready = rr;
    #1;
    wf = wv && wr_req_ready;
    rf = rv && rd_req_ready;
    if (rst_cmd) exp_q.delete();
    if (wf) shadow[int'(wa)] = wd;
    if (rf) exp_q.push_back(shadow.exists(int'(ra)) ? shadow[int'(ra)] : '0);
    if (rd_rsp_valid && rr && !rst_cmd) begin
      n_pop++;
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rd_rsp_valid), 64'(0));
      else                   chk("rsp_data", rd_rsp_data, exp_q.pop_front());
    end
  endtask

  task automatic idle(input bit rr, input int n);
    bit wf, rf;
    for (int i = 0; i < n; i++) tick(1'b0, '0, '0, 1'b0, '0, rr, wf, rf);
  endtask

  task automatic issue_read(input logic [AW-1:0] a, input bit rr, input int max, output bit ok);
    bit wf, rf;
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      tick(1'b0, '0, '0, 1'b1, a, rr, wf, rf);
      ok = rf;
    end
  endtask

  task automatic drain(input string tag, input int max);
    int n = 0;
    while (exp_q.size() != 0 && n < max) begin
      idle(1'b1, 1);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 64'(0));
  endtask

  task automatic chk_reset();
    chk("rst_ram_write",   64'(ram_write),      64'(0));
    chk("rst_ram_read",    64'(ram_read),       64'(0));
    chk("rst_ram_data_in", 64'(ram_data_in),    64'(0));
    chk("rst_ram_wr_addr", 64'(ram_wr_address), 64'(0));
    chk("rst_ram_rd_addr", 64'(ram_rd_address), 64'(0));
    chk("rst_wr_ready",    64'(wr_req_ready),   64'(0));
    chk("rst_rd_ready",    64'(rd_req_ready),   64'(0));
    chk("rst_rsp_valid",   64'(rd_rsp_valid),   64'(0));
    chk("rst_err",         64'(err_spurious),   64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit            wf, rf, ok, wp, rp;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd;
    int            pops0, acc, n;
    logic [AW-1:0] addrs [6];

    rst = 1'b1; wr_req_valid = 1'b0; wr_req_addr = '0; wr_req_data = '0;
    rd_req_valid = 1'b0; rd_req_addr = '0; rd_rsp_ready = 1'b0;

    // Reset state, then acceptance on the first cycle out of reset.
    rst_cmd = 1'b1;
    idle(1'b0, 2);
    chk_reset();
    rst_cmd = 1'b0;
    idle(1'b0, 1);
    chk("wr_ready_after_rst", 64'(wr_req_ready), 64'(1));
    chk("rd_ready_after_rst", 64'(rd_req_ready), 64'(1));
    idle(1'b0, 3);

    // Single write then read back.
    tick(1'b1, 12'h0A5, 64'hDEAD_BEEF_0000_0001, 1'b0, '0, 1'b1, wf, rf);
    chk("w0a5_accept", 64'(wf), 64'(1));
    idle(1'b1, 1);
    chk("w0a5_strobe", 64'(ram_write),      64'(1));
    chk("w0a5_addr",   64'(ram_wr_address), 64'h0A5);
    chk("w0a5_data",   ram_data_in,         64'hDEAD_BEEF_0000_0001);
    idle(1'b1, 1);
    chk("w0a5_pulse_end", 64'(ram_write), 64'(0));
    issue_read(12'h0A5, 1'b1, 10, ok);
    chk("r0a5_accept", 64'(ok), 64'(1));
    idle(1'b1, 1);
    chk("r0a5_strobe", 64'(ram_read),       64'(1));
    chk("r0a5_addr",   64'(ram_rd_address), 64'h0A5);
    drain("r0a5_drain", 50);

    // Same-cycle write and read of one address: read stalls until the write lands.
    tick(1'b1, 12'h3FF, 64'h1234_5678_9ABC_DEF0, 1'b1, 12'h3FF, 1'b1, wf, rf);
    chk("raw_w_accept", 64'(wf), 64'(1));
    chk("raw_cycle0_rd_ready", 64'(rf), 64'(0));
    tick(1'b0, '0, '0, 1'b1, 12'h3FF, 1'b1, wf, rf);
    chk("raw_cycle1_rd_ready", 64'(rf), 64'(0));
    tick(1'b0, '0, '0, 1'b1, 12'h3FF, 1'b1, wf, rf);
    chk("raw_cycle2_rd_ready", 64'(rf), 64'(1));
    drain("raw_drain", 50);

    // Independent write and read issue together.
    tick(1'b1, 12'h800, 64'hAAAA_5555_0000_FFFF, 1'b1, 12'h123, 1'b1, wf, rf);
    chk("dual_accept", 64'({wf, rf}), 64'(2'b11));
    idle(1'b1, 1);
    chk("dual_strobes", 64'({ram_write, ram_read}), 64'(2'b11));
    chk("dual_rd_addr", 64'(ram_rd_address), 64'h123);
    drain("dual_drain", 50);

    // Back-pressure: only RSP_DEPTH reads may be in flight or queued.
    addrs[0] = 12'h000; addrs[1] = 12'h400; addrs[2] = 12'h800;
    addrs[3] = 12'hC00; addrs[4] = 12'h001; addrs[5] = 12'h401;
    pops0 = n_pop;
    acc   = 0;
    for (int i = 0; i < 5; i++) begin
      issue_read(addrs[i], 1'b0, 12, ok);
      if (ok) acc++;
    end
    chk("bp_accepted", 64'(acc), 64'(4));
    chk("bp_rd_ready", 64'(rd_req_ready), 64'(0));
    issue_read(addrs[4], 1'b1, 30, ok);
    chk("bp_read4_after_release", 64'(ok), 64'(1));
    issue_read(addrs[5], 1'b1, 30, ok);
    chk("bp_read5_after_release", 64'(ok), 64'(1));
    drain("bp_drain", 100);
    chk("bp_pop_count", 64'(n_pop - pops0), 64'(6));

    // Random traffic over a small address pool to provoke hazards and stalls.
    wp = 1'b0; rp = 1'b0; wa = '0; ra = '0; wd = '0;
    for (int c = 0; c < 400; c++) begin
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1'b1;
        wa = 12'h3F0 + 12'($urandom_range(0, 7));
        wd = {$urandom, $urandom};
      end
      if (!rp && $urandom_range(0, 1) == 0) begin
        rp = 1'b1;
        ra = 12'h3F0 + 12'($urandom_range(0, 7));
      end
      tick(wp, wa, wd, rp, ra, ($urandom_range(0, 3) != 0), wf, rf);
      if (wf) wp = 1'b0;
      if (rf) rp = 1'b0;
    end
    n = 0;
    while ((wp || rp) && n < 50) begin
      tick(wp, wa, wd, rp, ra, 1'b1, wf, rf);
      if (wf) wp = 1'b0;
      if (rf) rp = 1'b0;
      n++;
    end
    chk("rand_pending", 64'({wp, rp}), 64'(0));
    drain("rand_drain", 200);
    chk("rand_err", 64'(err_spurious), 64'(0));

    // Stray RAM data well after reset sets the sticky error and queues nothing.
    rst_cmd = 1'b1;
    idle(1'b1, 2);
    rst_cmd = 1'b0;
    idle(1'b1, 5);
    spur_req++;
    idle(1'b1, 3);
    chk("spur_err_set",   64'(err_spurious), 64'(1));
    chk("spur_fifo_empty", 64'(rd_rsp_valid), 64'(0));
    rst_cmd = 1'b1;
    idle(1'b1, 2);
    chk("spur_err_cleared", 64'(err_spurious), 64'(0));
    chk_reset();
    rst_cmd = 1'b0;
    idle(1'b1, 4);

    // Reset with three responses queued and one read still inside the RAM.
    ram_jitter = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue_read(12'h010 + 12'(i), 1'b0, 10, ok);
      chk("flush_read_accept", 64'(ok), 64'(1));
    end
    idle(1'b0, 6);
    chk("flush_queued", 64'(rd_rsp_valid), 64'(1));
    ram_hold = 1'b1;
    issue_read(12'h020, 1'b0, 10, ok);
    chk("flush_read4_accept", 64'(ok), 64'(1));
    idle(1'b0, 3);
    rst_cmd = 1'b1;
    idle(1'b1, 1);
    ram_hold = 1'b0;
    rst_cmd  = 1'b0;
    idle(1'b1, 1);
    chk("flush_rsp_valid", 64'(rd_rsp_valid), 64'(0));
    for (int i = 0; i < 4; i++) begin
      idle(1'b1, 1);
      chk("flush_drain_err", 64'(err_spurious), 64'(0));
      chk("flush_drain_rsp", 64'(rd_rsp_valid), 64'(0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
